// File: rtl/ctrl_cnt_vol_nd_if.sv
// Control/status bundle between the convolution main FSM (master) and the
// three-level volume counter (slave).
interface ctrl_cnt_vol_nd_if #(
    parameter int MAX_X = 224,
    parameter int MAX_Y = 224,
    parameter int MAX_C = 512
);
    localparam int WX = $clog2(MAX_X + 1);
    localparam int WY = $clog2(MAX_Y + 1);
    localparam int WC = $clog2(MAX_C + 1);

    logic          cnt_clear;
    logic          cnt_load;
    logic [WX-1:0] max_x;
    logic [WY-1:0] max_y;
    logic [WC-1:0] max_c;
    logic          cnt_start;
    logic          cnt_step;

    logic [WX-1:0] cur_x;
    logic [WY-1:0] cur_y;
    logic [WC-1:0] cur_c;
    logic          wrap_x;
    logic          wrap_y;
    logic          last_vol;
    logic          busy;
    logic          op_done;
    logic          cfg_err;

    modport master (
        output cnt_clear, cnt_load, max_x, max_y, max_c, cnt_start, cnt_step,
        input  cur_x, cur_y, cur_c, wrap_x, wrap_y, last_vol, busy, op_done, cfg_err
    );

    modport slave (
        input  cnt_clear, cnt_load, max_x, max_y, max_c, cnt_start, cnt_step,
        output cur_x, cur_y, cur_c, wrap_x, wrap_y, last_vol, busy, op_done, cfg_err
    );
endinterface

// File: rtl/ctrl_cnt_vol_nd.sv
// Three-level (x fastest, then y, then c) programmable volume counter with
// limit checking, wrap pulses and an IDLE/ARMED/RUN/DONE state machine.
module ctrl_cnt_vol_nd #(
    parameter int MAX_X = 224,
    parameter int MAX_Y = 224,
    parameter int MAX_C = 512
) (
    input logic              clk,
    input logic              rst,
    ctrl_cnt_vol_nd_if.slave bus
);
    localparam int WX = $clog2(MAX_X + 1);
    localparam int WY = $clog2(MAX_Y + 1);
    localparam int WC = $clog2(MAX_C + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [WX-1:0] cur_x_q, cur_x_d, lim_x_q, lim_x_d;
    logic [WY-1:0] cur_y_q, cur_y_d, lim_y_q, lim_y_d;
    logic [WC-1:0] cur_c_q, cur_c_d, lim_c_q, lim_c_d;
    logic          wrap_x_q, wrap_x_d;
    logic          wrap_y_q, wrap_y_d;
    logic          last_vol_q, last_vol_d;
    logic          cfg_err_q, cfg_err_d;
    logic          load_ok;

    always_comb begin
        load_ok = (bus.max_x != '0) && (bus.max_x <= WX'(MAX_X)) &&
                  (bus.max_y != '0) && (bus.max_y <= WY'(MAX_Y)) &&
                  (bus.max_c != '0) && (bus.max_c <= WC'(MAX_C));
    end

    always_comb begin
        state_d   = state_q;
        cur_x_d   = cur_x_q;
        cur_y_d   = cur_y_q;
        cur_c_d   = cur_c_q;
        lim_x_d   = lim_x_q;
        lim_y_d   = lim_y_q;
        lim_c_d   = lim_c_q;
        wrap_x_d  = 1'b0;
        wrap_y_d  = 1'b0;
        cfg_err_d = cfg_err_q;

        if (bus.cnt_clear) begin
            state_d   = ST_IDLE;
            cur_x_d   = WX'(1);
            cur_y_d   = WY'(1);
            cur_c_d   = WC'(1);
            lim_x_d   = '0;
            lim_y_d   = '0;
            lim_c_d   = '0;
            cfg_err_d = 1'b0;
        end else if (bus.cnt_load && (state_q != ST_RUN)) begin
            cur_x_d = WX'(1);
            cur_y_d = WY'(1);
            cur_c_d = WC'(1);
            if (load_ok) begin
                state_d   = ST_ARMED;
                lim_x_d   = bus.max_x;
                lim_y_d   = bus.max_y;
                lim_c_d   = bus.max_c;
                cfg_err_d = 1'b0;
            end else begin
                state_d   = ST_IDLE;
                lim_x_d   = '0;
                lim_y_d   = '0;
                lim_c_d   = '0;
                cfg_err_d = 1'b1;
            end
        end else if (bus.cnt_start && (state_q == ST_ARMED || state_q == ST_DONE)) begin
            state_d = ST_RUN;
            cur_x_d = WX'(1);
            cur_y_d = WY'(1);
            cur_c_d = WC'(1);
        end else if (bus.cnt_step && (state_q == ST_RUN)) begin
            if (cur_x_q < lim_x_q) begin
                cur_x_d = cur_x_q + WX'(1);
            end else begin
                cur_x_d  = WX'(1);
                wrap_x_d = 1'b1;
                if (cur_y_q < lim_y_q) begin
                    cur_y_d = cur_y_q + WY'(1);
                end else begin
                    cur_y_d  = WY'(1);
                    wrap_y_d = 1'b1;
                    if (cur_c_q < lim_c_q) begin
                        cur_c_d = cur_c_q + WC'(1);
                    end else begin
                        // Final volume of the layer: rewind so a restart from DONE starts clean.
                        cur_c_d = WC'(1);
                        state_d = ST_DONE;
                    end
                end
            end
        end

        last_vol_d = (state_d == ST_RUN) && (cur_x_d == lim_x_d) &&
                     (cur_y_d == lim_y_d) && (cur_c_d == lim_c_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cur_x_q    <= WX'(1);
            cur_y_q    <= WY'(1);
            cur_c_q    <= WC'(1);
            lim_x_q    <= '0;
            lim_y_q    <= '0;
            lim_c_q    <= '0;
            wrap_x_q   <= 1'b0;
            wrap_y_q   <= 1'b0;
            last_vol_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            cur_c_q    <= cur_c_d;
            lim_x_q    <= lim_x_d;
            lim_y_q    <= lim_y_d;
            lim_c_q    <= lim_c_d;
            wrap_x_q   <= wrap_x_d;
            wrap_y_q   <= wrap_y_d;
            last_vol_q <= last_vol_d;
            cfg_err_q  <= cfg_err_d;
        end
    end

    assign bus.cur_x    = cur_x_q;
    assign bus.cur_y    = cur_y_q;
    assign bus.cur_c    = cur_c_q;
    assign bus.wrap_x   = wrap_x_q;
    assign bus.wrap_y   = wrap_y_q;
    assign bus.last_vol = last_vol_q;
    assign bus.busy     = (state_q == ST_RUN);
    assign bus.op_done  = (state_q == ST_DONE);
    assign bus.cfg_err  = cfg_err_q;
endmodule

// File: tb/tb_ctrl_cnt_vol_nd.sv
// Directed self-checking bench for the three-level volume counter; expected
// positions come from a small reference stepping model kept in the bench.
module tb_ctrl_cnt_vol_nd;
    localparam int MAX_X = 224;
    localparam int MAX_Y = 224;
    localparam int MAX_C = 512;
    localparam int WX = $clog2(MAX_X + 1);
    localparam int WY = $clog2(MAX_Y + 1);
    localparam int WC = $clog2(MAX_C + 1);

    logic clk;
    logic rst;

    int checks;
    int errors;

    int  ex, ey, ec;
    logic exp_wx, exp_wy;
    logic running;

    ctrl_cnt_vol_nd_if #(.MAX_X(MAX_X), .MAX_Y(MAX_Y), .MAX_C(MAX_C)) bus ();

    ctrl_cnt_vol_nd #(.MAX_X(MAX_X), .MAX_Y(MAX_Y), .MAX_C(MAX_C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value and log any difference.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Present one cycle of inputs, let one rising edge consume them, then idle the inputs.
    task automatic applyStimulus(input logic clr, input logic ld, input int mx,
                                 input int my, input int mc, input logic st,
                                 input logic sp);
        bus.cnt_clear = clr;
        bus.cnt_load  = ld;
        bus.max_x     = mx[WX-1:0];
        bus.max_y     = my[WY-1:0];
        bus.max_c     = mc[WC-1:0];
        bus.cnt_start = st;
        bus.cnt_step  = sp;
        @(posedge clk);
        #1;
        bus.cnt_clear = 1'b0;
        bus.cnt_load  = 1'b0;
        bus.cnt_start = 1'b0;
        bus.cnt_step  = 1'b0;
    endtask

    task automatic model_reset_pos();
        ex = 1; ey = 1; ec = 1;
        exp_wx = 1'b0; exp_wy = 1'b0;
    endtask

    // Reference order: x fastest, then y, then channel group; the final step ends the run.
    task automatic model_step(input int lx, input int ly, input int lc);
        exp_wx = 1'b0;
        exp_wy = 1'b0;
        if (ex < lx) ex++;
        else begin
            ex = 1; exp_wx = 1'b1;
            if (ey < ly) ey++;
            else begin
                ey = 1; exp_wy = 1'b1;
                if (ec < lc) ec++;
                else begin
                    ec = 1; running = 1'b0;
                end
            end
        end
    endtask

    task automatic check_pos(input string tag, input int lx, input int ly, input int lc);
        logic exp_last;
        exp_last = running && (ex == lx) && (ey == ly) && (ec == lc);
        checkOutput({tag, ".cur_x"},    32'(bus.cur_x),    32'(ex));
        checkOutput({tag, ".cur_y"},    32'(bus.cur_y),    32'(ey));
        checkOutput({tag, ".cur_c"},    32'(bus.cur_c),    32'(ec));
        checkOutput({tag, ".wrap_x"},   32'(bus.wrap_x),   32'(exp_wx));
        checkOutput({tag, ".wrap_y"},   32'(bus.wrap_y),   32'(exp_wy));
        checkOutput({tag, ".last_vol"}, 32'(bus.last_vol), 32'(exp_last));
        checkOutput({tag, ".busy"},     32'(bus.busy),     32'(running));
        checkOutput({tag, ".op_done"},  32'(bus.op_done),  32'(!running));
    endtask

    task automatic run_steps(input string tag, input int n, input int lx,
                             input int ly, input int lc);
        for (int k = 1; k <= n; k++) begin
            applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
            model_step(lx, ly, lc);
            check_pos($sformatf("%s.s%0d", tag, k), lx, ly, lc);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        running = 1'b0;
        bus.cnt_clear = 1'b0;
        bus.cnt_load  = 1'b0;
        bus.cnt_start = 1'b0;
        bus.cnt_step  = 1'b0;
        bus.max_x = '0;
        bus.max_y = '0;
        bus.max_c = '0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        model_reset_pos();
        running = 1'b0;
        checkOutput("rst.cur_x",    32'(bus.cur_x),    1);
        checkOutput("rst.cur_y",    32'(bus.cur_y),    1);
        checkOutput("rst.cur_c",    32'(bus.cur_c),    1);
        checkOutput("rst.wrap_x",   32'(bus.wrap_x),   0);
        checkOutput("rst.wrap_y",   32'(bus.wrap_y),   0);
        checkOutput("rst.last_vol", 32'(bus.last_vol), 0);
        checkOutput("rst.busy",     32'(bus.busy),     0);
        checkOutput("rst.op_done",  32'(bus.op_done),  0);
        checkOutput("rst.cfg_err",  32'(bus.cfg_err),  0);
        rst = 1'b0;
        @(negedge clk);

        // (3,2,2): 12 back-to-back steps to DONE
        applyStimulus(1'b0, 1'b1, 3, 2, 2, 1'b0, 1'b0);
        checkOutput("a.load.busy",    32'(bus.busy),    0);
        checkOutput("a.load.cfg_err", 32'(bus.cfg_err), 0);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        model_reset_pos();
        running = 1'b1;
        check_pos("a.start", 3, 2, 2);
        run_steps("a", 12, 3, 2, 2);

        // Rejected loads; a start afterwards must not run
        applyStimulus(1'b0, 1'b1, 0, 5, 5, 1'b0, 1'b0);
        checkOutput("b.zero.cfg_err", 32'(bus.cfg_err), 1);
        checkOutput("b.zero.op_done", 32'(bus.op_done), 0);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        checkOutput("b.zero.start_busy", 32'(bus.busy), 0);
        applyStimulus(1'b0, 1'b1, MAX_X, MAX_Y, MAX_C, 1'b0, 1'b0);
        checkOutput("b.max.cfg_err", 32'(bus.cfg_err), 0);
        applyStimulus(1'b0, 1'b1, MAX_X + 1, 1, 1, 1'b0, 1'b0);
        checkOutput("b.over.cfg_err", 32'(bus.cfg_err), 1);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        checkOutput("b.over.start_busy", 32'(bus.busy), 0);
        applyStimulus(1'b0, 1'b1, 1, 1, MAX_C + 1, 1'b0, 1'b0);
        checkOutput("b.overc.cfg_err", 32'(bus.cfg_err), 1);

        // All limits 1: last volume at once, one step finishes
        applyStimulus(1'b0, 1'b1, 1, 1, 1, 1'b0, 1'b0);
        checkOutput("c.load.cfg_err", 32'(bus.cfg_err), 0);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        model_reset_pos();
        running = 1'b1;
        check_pos("c.start", 1, 1, 1);
        run_steps("c", 1, 1, 1, 1);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0);
        checkOutput("c.idle.wrap_x",  32'(bus.wrap_x),  0);
        checkOutput("c.idle.wrap_y",  32'(bus.wrap_y),  0);
        checkOutput("c.idle.op_done", 32'(bus.op_done), 1);

        // Clear beats a simultaneous step mid-run
        applyStimulus(1'b0, 1'b1, 4, 4, 1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        model_reset_pos();
        running = 1'b1;
        run_steps("d", 5, 4, 4, 1);
        applyStimulus(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        model_reset_pos();
        running = 1'b0;
        checkOutput("d.clr.cur_x",   32'(bus.cur_x),   1);
        checkOutput("d.clr.cur_y",   32'(bus.cur_y),   1);
        checkOutput("d.clr.cur_c",   32'(bus.cur_c),   1);
        checkOutput("d.clr.busy",    32'(bus.busy),    0);
        checkOutput("d.clr.op_done", 32'(bus.op_done), 0);
        checkOutput("d.clr.wrap_x",  32'(bus.wrap_x),  0);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        checkOutput("d.step.cur_x", 32'(bus.cur_x), 1);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        checkOutput("d.start.busy", 32'(bus.busy), 0);

        // Full run, restart from DONE without reload; a load during RUN is ignored
        applyStimulus(1'b0, 1'b1, 4, 4, 1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        model_reset_pos();
        running = 1'b1;
        run_steps("e1", 16, 4, 4, 1);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        model_reset_pos();
        running = 1'b1;
        check_pos("e2.start", 4, 4, 1);
        run_steps("e2a", 5, 4, 4, 1);
        applyStimulus(1'b0, 1'b1, 1, 1, 1, 1'b0, 1'b0);
        exp_wx = 1'b0; exp_wy = 1'b0;
        check_pos("e2.load", 4, 4, 1);
        checkOutput("e2.load.cfg_err", 32'(bus.cfg_err), 0);
        run_steps("e2b", 11, 4, 4, 1);

        // Asynchronous reset between edges mid-run
        applyStimulus(1'b0, 1'b1, 3, 2, 2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        model_reset_pos();
        running = 1'b1;
        run_steps("f", 2, 3, 2, 2);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("f.arst.cur_x", 32'(bus.cur_x), 1);
        checkOutput("f.arst.busy",  32'(bus.busy),  0);
        bus.cnt_step = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.cnt_step = 1'b0;
        checkOutput("f.hold.cur_x", 32'(bus.cur_x), 1);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        checkOutput("f.start.busy", 32'(bus.busy), 0);
        applyStimulus(1'b0, 1'b1, 3, 2, 2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b1, 1'b0);
        checkOutput("f.rerun.busy", 32'(bus.busy), 1);
        applyStimulus(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b1);
        checkOutput("f.rerun.cur_x", 32'(bus.cur_x), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
